mycpu_div: RTL and testbench

//  Multi-cycle 32-bit divider (radix-2 restoring, 1 quotient bit/cycle) attached to EX stage.
//  EX launches DIV/DIVU here; it raises stallreq_for_ex while a divide is in flight and !ready_o.

---
 rtl/mycpu_div_pkg.sv | 21 ++
 rtl/mycpu_div_if.sv | 24 ++
 rtl/mycpu_div.sv | 148 ++++++++++++++
 tb/tb_mycpu_div.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mycpu_div_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding, widths,
// and a small two's-complement helper.
package mycpu_div_pkg;

    localparam int DIV_DW           = 32;
    localparam int DIV_RESULT_BUS_W = 64;

    // Encodings are shared with EX (stall request and result bus decode).
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Two's-complement negation at the operand width.
    function automatic logic [DIV_DW-1:0] neg_dw(input logic [DIV_DW-1:0] x);
        return ~x + {{(DIV_DW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mycpu_div_if.sv
// EX <-> divider request/response bundle. EX is the master, the divider the slave.
interface mycpu_div_if
    import mycpu_div_pkg::*;
#(
    parameter int DW = DIV_DW
);
    logic            signed_div_i;
    logic [DW-1:0]   opdata1_i;
    logic [DW-1:0]   opdata2_i;
    logic            start_i;
    logic            annul_i;
    logic [2*DW-1:0] result_o;
    logic            ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/mycpu_div.sv
// Radix-2 restoring divider, one quotient bit per cycle. Operands are
// reduced to magnitudes at launch; the signs are re-applied once at the end.
// result_o = {remainder, quotient}; ready_o stays high until start_i drops.
module mycpu_div
    import mycpu_div_pkg::*;
#(
    parameter int DW = DIV_DW
)(
    input  logic          clk,
    input  logic          rst,
    mycpu_div_if.slave    div_bus
);

    localparam logic [DW-1:0] ONE_W    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [5:0]    CNT_LAST = 6'(DW);

    div_state_e      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [2*DW:0]   w_q, w_d;
    logic [DW-1:0]   divisor_q, divisor_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [2*DW-1:0] result_q, result_d;
    logic            ready_q, ready_d;

    logic [DW-1:0]   dividend_abs_s;
    logic [DW-1:0]   divisor_abs_s;
    logic [DW:0]     diff_s;
    logic [DW-1:0]   quot_s;
    logic [DW-1:0]   rem_s;

    // Magnitudes at launch; 0x80000000 negates to itself and is then read as unsigned.
    assign dividend_abs_s = (div_bus.signed_div_i && div_bus.opdata1_i[DW-1])
                          ? (~div_bus.opdata1_i + ONE_W) : div_bus.opdata1_i;
    assign divisor_abs_s  = (div_bus.signed_div_i && div_bus.opdata2_i[DW-1])
                          ? (~div_bus.opdata2_i + ONE_W) : div_bus.opdata2_i;

    // Trial subtraction of the divisor from the upper partial remainder.
    assign diff_s = w_q[2*DW:DW] - {1'b0, divisor_q};

    // Sign fix applied to the final magnitudes.
    assign quot_s = neg_quot_q ? (~w_q[DW-1:0] + ONE_W) : w_q[DW-1:0];
    assign rem_s  = neg_rem_q  ? (~w_q[2*DW:DW+1] + ONE_W) : w_q[2*DW:DW+1];

    assign div_bus.result_o = result_q;
    assign div_bus.ready_o  = ready_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= 6'd0;
            w_q        <= {(2*DW+1){1'b0}};
            divisor_q  <= {DW{1'b0}};
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= {(2*DW){1'b0}};
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state, iteration step and output register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = 1'b0;
                result_d = {(2*DW){1'b0}};
                if (div_bus.start_i && !div_bus.annul_i) begin
                    if (div_bus.opdata2_i == {DW{1'b0}}) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = 6'd0;
                        w_d        = {{DW{1'b0}}, dividend_abs_s, 1'b0};
                        divisor_d  = divisor_abs_s;
                        neg_quot_d = div_bus.signed_div_i
                                   & (div_bus.opdata1_i[DW-1] ^ div_bus.opdata2_i[DW-1]);
                        neg_rem_d  = div_bus.signed_div_i & div_bus.opdata1_i[DW-1];
                    end
                end else begin
                    state_d = DIV_FREE;
                end
            end
            DIV_BYZERO: begin
                result_d = {(2*DW){1'b0}};
                if (div_bus.annul_i) begin
                    state_d = DIV_FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d = DIV_END;
                    ready_d = 1'b1;
                end
            end
            DIV_ON: begin
                if (div_bus.annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = {(2*DW){1'b0}};
                end else if (cnt_q != CNT_LAST) begin
                    if (!diff_s[DW]) begin
                        w_d = {diff_s[DW-1:0], w_q[DW-1:0], 1'b1};
                    end else begin
                        w_d = {w_q[2*DW-1:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DIV_END;
                    result_d = {rem_s, quot_s};
                    ready_d  = 1'b1;
                end
            end
            DIV_END: begin
                // Result held until EX drops its request; no relaunch while start_i stays high.
                if (div_bus.annul_i || !div_bus.start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = {(2*DW){1'b0}};
                end else begin
                    state_d = DIV_END;
                end
            end
            default: begin
                state_d  = DIV_FREE;
                ready_d  = 1'b0;
                result_d = {(2*DW){1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_mycpu_div.sv
// Directed bench for mycpu_div. Expected results are queued when an op is
// launched; a negedge monitor pops one entry on every rising ready_o.
module tb_mycpu_div;
    import mycpu_div_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic rdy_prev;
    logic [63:0] sb[$];

    mycpu_div_if #(.DW(32)) bus ();

    mycpu_div #(.DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && rdy_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready: got result %h expected no ready", bus.result_o);
            end else begin
                chk64("scoreboard_result", bus.result_o, sb.pop_front());
            end
        end
        rdy_prev = bus.ready_o;
    end

    task automatic set_op(input logic sd, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sd;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
    endtask

    // Wait for ready (bounded), check latency, hold start for one more cycle, then release.
    task automatic finish_op(input string name, input logic [63:0] exp, input int lat,
                             input bit end_by_annul);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                // Latched copies must be used; scramble the live operands.
                bus.opdata1_i    = 32'h5A5A_A5A5;
                bus.opdata2_i    = 32'h0000_0000;
                bus.signed_div_i = ~bus.signed_div_i;
            end
        end while (bus.ready_o !== 1'b1 && n < 60);
        chk_int({name, "_latency"}, n, lat + 1);
        @(posedge clk); #1;
        chk1({name, "_hold_ready"}, bus.ready_o, 1'b1);
        chk64({name, "_hold_result"}, bus.result_o, exp);
        if (end_by_annul) begin
            bus.annul_i = 1'b1;
        end else begin
            bus.start_i = 1'b0;
        end
        @(posedge clk); #1;
        chk1({name, "_release_ready"}, bus.ready_o, 1'b0);
        chk64({name, "_release_result"}, bus.result_o, 64'h0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_div(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input bit end_by_annul);
        sb.push_back(exp);
        set_op(sd, a, b);
        finish_op(name, exp, lat, end_by_annul);
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rdy_prev = 1'b0;
        rst      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h0;
        bus.opdata2_i    = 32'h0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_ready", bus.ready_o, 1'b0);
        chk64("reset_result", bus.result_o, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div("divu_7_2",      1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 33, 1'b0);
        do_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
        do_div("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 1'b0);
        do_div("div_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 1'b0);
        do_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 1'b0);
        do_div("div_m100_7",    1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 33, 1'b0);
        do_div("divu_5_9",      1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33, 1'b0);
        do_div("div_min_2",     1'b1, 32'h80000000,   32'd2,          64'h00000000_C0000000, 33, 1'b0);
        do_div("divu_max_16",   1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF, 33, 1'b1);
        do_div("divu_by_zero",  1'b0, 32'd123,        32'd0,          64'h0, 1, 1'b0);
        do_div("div_by_zero",   1'b1, 32'h80000000,   32'd0,          64'h0, 1, 1'b0);

        // Annul at cnt=10 (start held), then an immediate new DIVU 100/7.
        set_op(1'b0, 32'hFFFFFFFF, 32'd3);
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        chk1("annul_ready", bus.ready_o, 1'b0);
        chk64("annul_result", bus.result_o, 64'h0);
        sb.push_back(64'h00000002_0000000E);
        set_op(1'b0, 32'd100, 32'd7);
        finish_op("divu_100_7_after_annul", 64'h00000002_0000000E, 33, 1'b0);

        // Reset pulse at cnt=20: op abandoned, no stale ready afterwards.
        set_op(1'b1, 32'hFFFFFFF9, 32'd2);
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        chk1("midrst_ready", bus.ready_o, 1'b0);
        chk64("midrst_result", bus.result_o, 64'h0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk1("midrst_no_stale_ready", bus.ready_o, 1'b0);

        chk_int("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
